// File: rtl/acl2_meas_text_formatter.sv
// ACL2 sample -> ASCII text line formatter.
// Turns one 8-byte X/Y/Z/Temp burst into "X=hhhh Y=hhhh Z=hhhh T=hhhh" plus
// a line ending, and streams it one byte at a time over a valid/ready link.
// A one-deep pending slot holds a sample that arrives while a line is being
// sent; if a second one arrives before the slot drains, the older pending
// sample is overwritten and counted as a drop.
module acl2_meas_text_formatter #(
  parameter bit parm_lower_hex = 1'b0,
  parameter bit parm_crlf      = 1'b1,
  parameter int parm_drop_bits = 8
) (
  input  logic                      i_clk_20mhz,
  input  logic                      i_rstn_20mhz,
  input  logic [63:0]               i_data_3axis_temp,
  input  logic                      i_data_valid,
  output logic [7:0]                o_tx_data,
  output logic                      o_tx_valid,
  input  logic                      i_tx_ready,
  output logic                      o_busy,
  output logic                      o_line_done,
  output logic [parm_drop_bits-1:0] o_drop_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_DONE} state_e;

  // Index of the final character; it depends on whether CR precedes LF.
  localparam logic [4:0] LAST = parm_crlf ? 5'd28 : 5'd27;
  localparam logic [7:0] CH_X = 8'h58;

  state_e                    state_q, state_d;
  logic [4:0]                idx_q, idx_d;
  logic [63:0]               act_q, act_d;
  logic [63:0]               pend_q, pend_d;
  logic                      pfull_q, pfull_d;
  logic [parm_drop_bits-1:0] drop_q, drop_d;
  logic [7:0]                txd_q, txd_d;
  logic                      start, consume;

  // Character at position idx of the line for sample s. Each field is 7
  // characters wide ("X=hhhh "); the last field has no trailing space
  // because the line ending takes its place.
  function automatic logic [7:0] char_at(input logic [63:0] s, input logic [4:0] idx);
    logic [1:0]  f;
    logic [2:0]  pos;
    logic [15:0] w;
    logic [3:0]  n;
    logic [7:0]  c;
    f   = 2'd3;
    pos = 3'(idx - 5'd21);
    if (idx < 5'd7) begin
      f = 2'd0; pos = 3'(idx);
    end else if (idx < 5'd14) begin
      f = 2'd1; pos = 3'(idx - 5'd7);
    end else if (idx < 5'd21) begin
      f = 2'd2; pos = 3'(idx - 5'd14);
    end
    // Fields print {H,L}; the burst carries L first.
    case (f)
      2'd0:    w = {s[55:48], s[63:56]};
      2'd1:    w = {s[39:32], s[47:40]};
      2'd2:    w = {s[23:16], s[31:24]};
      default: w = {s[7:0],   s[15:8]};
    endcase
    case (pos)
      3'd2:    n = w[15:12];
      3'd3:    n = w[11:8];
      3'd4:    n = w[7:4];
      default: n = w[3:0];
    endcase
    if (n < 4'd10) c = 8'h30 + {4'h0, n};
    else           c = (parm_lower_hex ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
    if (idx >= 5'd27) begin
      c = (idx == 5'd27 && parm_crlf) ? 8'h0D : 8'h0A;
    end else if (pos == 3'd0) begin
      case (f)
        2'd0:    c = 8'h58;
        2'd1:    c = 8'h59;
        2'd2:    c = 8'h5A;
        default: c = 8'h54;
      endcase
    end else if (pos == 3'd1) begin
      c = 8'h3D;
    end else if (pos == 3'd6) begin
      c = 8'h20;
    end
    return c;
  endfunction

  // Next-state: line sequencing, pending slot management and drop counting.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    act_d   = act_q;
    pend_d  = pend_q;
    pfull_d = pfull_q;
    drop_d  = drop_q;
    txd_d   = txd_q;
    start   = 1'b0;
    consume = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A sample left pending across DONE->IDLE is served before new input.
        if (pfull_q) begin
          act_d = pend_q; consume = 1'b1; start = 1'b1;
        end else if (i_data_valid) begin
          act_d = i_data_3axis_temp; start = 1'b1;
        end
      end
      ST_EMIT: begin
        if (i_tx_ready) begin
          if (idx_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 5'd1;
            txd_d = char_at(act_q, idx_q + 5'd1);
          end
        end
      end
      ST_DONE: begin
        // Only the pending contents seen at the start of this cycle are loaded.
        if (pfull_q) begin
          act_d = pend_q; consume = 1'b1; start = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d = ST_EMIT;
      idx_d   = 5'd0;
      txd_d   = CH_X;
    end
    if (consume) pfull_d = 1'b0;
    // A sample is a drop only when it displaces one that nobody consumed.
    if (i_data_valid && (state_q != ST_IDLE || pfull_q)) begin
      if (pfull_q && !consume && drop_q != {parm_drop_bits{1'b1}})
        drop_d = drop_q + {{(parm_drop_bits-1){1'b0}}, 1'b1};
      pend_d  = i_data_3axis_temp;
      pfull_d = 1'b1;
    end
  end

  // State registers; reset aborts any line in flight.
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      state_q <= ST_IDLE;
      idx_q   <= 5'd0;
      act_q   <= 64'd0;
      pend_q  <= 64'd0;
      pfull_q <= 1'b0;
      drop_q  <= '0;
      txd_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pfull_q <= pfull_d;
      drop_q  <= drop_d;
      txd_q   <= txd_d;
    end
  end

  assign o_tx_data    = txd_q;
  assign o_tx_valid   = (state_q == ST_EMIT);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_line_done  = (state_q == ST_DONE);
  assign o_drop_count = drop_q;

endmodule

// File: tb/tb_acl2_meas_text_formatter.sv
// Bench for acl2_meas_text_formatter: table of known lines, randomized
// samples/ready against a string-building model, and hand sequences for
// stall, pending/drop, coincident valid and mid-line reset.
module tb_acl2_meas_text_formatter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] data = 64'd0;
  logic        valid = 1'b0;
  logic        ready = 1'b1;
  logic [7:0]  txd, txd2, drop, drop2;
  logic        txv, txv2, busy, busy2, ld, ld2;

  always #25 clk = ~clk;

  acl2_meas_text_formatter dut (
    .i_clk_20mhz(clk), .i_rstn_20mhz(rst_n), .i_data_3axis_temp(data),
    .i_data_valid(valid), .o_tx_data(txd), .o_tx_valid(txv), .i_tx_ready(ready),
    .o_busy(busy), .o_line_done(ld), .o_drop_count(drop));

  acl2_meas_text_formatter #(.parm_lower_hex(1'b1), .parm_crlf(1'b0)) dut2 (
    .i_clk_20mhz(clk), .i_rstn_20mhz(rst_n), .i_data_3axis_temp(data),
    .i_data_valid(valid), .o_tx_data(txd2), .o_tx_valid(txv2), .i_tx_ready(1'b1),
    .o_busy(busy2), .o_line_done(ld2), .o_drop_count(drop2));

  int   total = 0, bad = 0, cyc = 0, ld_cnt = 0;
  byte  rxq[$], rxq2[$];
  int   accq[$];
  logic prev_stall = 1'b0;
  logic [7:0] prev_d = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect accepted characters and check hold-while-stalled.
  always @(negedge clk) begin
    if (prev_stall) begin
      total++;
      if (!(txv && txd == prev_d)) begin
        bad++;
        $display("FAIL stall_hold: got valid=%0b data=%02h, want valid=1 data=%02h", txv, txd, prev_d);
      end
    end
    prev_stall = rst_n && txv && !ready;
    prev_d     = txd;
    if (rst_n && txv && ready) begin rxq.push_back(txd); accq.push_back(cyc); end
    if (rst_n && txv2) rxq2.push_back(txd2);
    if (ld) ld_cnt++;
  end

  // Reference: line text built directly from the field layout.
  function automatic string model_line(logic [63:0] s, bit lower, bit crlf);
    string r = "";
    string names = "XYZT";
    for (int f = 0; f < 4; f++) begin
      logic [15:0] v;
      v = {s[55-16*f -: 8], s[63-16*f -: 8]};
      r = $sformatf("%s%c=", r, names[f]);
      for (int k = 3; k >= 0; k--) begin
        int nib = (v >> (4*k)) & 15;
        int ch  = (nib < 10) ? (48 + nib) : ((lower ? 97 : 65) + nib - 10);
        r = $sformatf("%s%c", r, ch[7:0]);
      end
      if (f < 3) r = {r, " "};
    end
    r = crlf ? {r, "\r\n"} : {r, "\n"};
    return r;
  endfunction

  function automatic string vis(string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D)      r = {r, "<CR>"};
      else if (s[i] == 8'h0A) r = {r, "<LF>"};
      else                    r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  function automatic string q2s(input byte q[$]);
    string r = "";
    foreach (q[i]) r = $sformatf("%s%c", r, q[i]);
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic chk_str(string name, string got, string exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got \"%s\" want \"%s\"", name, vis(got), vis(exp));
    end
  endtask

  int send_cyc;
  task automatic send(logic [63:0] s);
    @(posedge clk); #1;
    data = s; valid = 1'b1; send_cyc = cyc;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_idle(int bound, bit rnd);
    int n = 0;
    while (busy && n < bound) begin
      @(posedge clk); #1;
      if (rnd) ready = 1'($urandom_range(0, 1));
      n++;
    end
    ready = 1'b1;
    total++;
    if (busy) begin bad++; $display("FAIL wait_idle: still busy after %0d cycles", bound); end
    @(posedge clk); #1;
  endtask

  typedef struct { logic [63:0] s; string line; } vec_t;
  vec_t vecs[4];

  initial begin
    logic [63:0] s;
    int d0;
    vecs[0] = '{64'h1A00_F0FF_0200_E803, "X=001A Y=FFF0 Z=0002 T=03E8\r\n"};
    vecs[1] = '{64'h0000_0000_0000_0000, "X=0000 Y=0000 Z=0000 T=0000\r\n"};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, "X=FFFF Y=FFFF Z=FFFF T=FFFF\r\n"};
    vecs[3] = '{64'h3412_7856_BC9A_F0DE, "X=1234 Y=5678 Z=9ABC T=DEF0\r\n"};

    // 1: reset holds outputs at 0 regardless of inputs.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      data = {$urandom, $urandom}; valid = 1'($urandom_range(0, 1)); ready = 1'($urandom_range(0, 1));
      #5;
      chk("reset_outputs", {txv, txd, busy, ld, drop, txv2, busy2, drop2}, 64'd0);
    end
    valid = 1'b0; ready = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {busy, txv, ld}, 64'd0);

    // 2: table of known lines with ready held high.
    foreach (vecs[i]) begin
      rxq.delete(); accq.delete(); rxq2.delete(); d0 = ld_cnt;
      send(vecs[i].s);
      wait_idle(200, 1'b0);
      chk_str($sformatf("line_vec%0d", i), q2s(rxq), vecs[i].line);
      chk_str($sformatf("line_lower_lf_vec%0d", i), q2s(rxq2), model_line(vecs[i].s, 1'b1, 1'b0));
      if (accq.size() == 29) begin
        chk("first_char_latency", 64'(accq[0] - send_cyc), 64'd1);
        chk("back_to_back_chars", 64'(accq[28] - accq[0]), 64'd28);
      end
      chk("line_done_pulses", 64'(ld_cnt - d0), 64'd1);
    end

    // 3: stall 10 cycles at char 5, then random ready.
    rxq.delete();
    send(vecs[0].s);
    for (int n = 0; n < 100 && rxq.size() < 5; n++) begin @(posedge clk); #1; end
    ready = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    wait_idle(2000, 1'b1);
    chk_str("stall_line", q2s(rxq), vecs[0].line);

    // Randomized samples and ready against the model.
    for (int i = 0; i < 6; i++) begin
      rxq.delete();
      s = {$urandom, $urandom};
      send(s);
      wait_idle(2000, 1'b1);
      chk_str($sformatf("rand_line%0d", i), q2s(rxq), model_line(s, 1'b0, 1'b1));
    end
    chk("drops_before_overrun", 64'(drop), 64'd0);

    // 4: A, B, C in one line -> A then C, one drop.
    rxq.delete(); d0 = ld_cnt;
    send(64'h0100_0200_0300_0400);
    repeat (3) @(posedge clk);
    send(64'h1100_1200_1300_1400);
    send(64'h2100_2200_2300_2400);
    wait_idle(500, 1'b0);
    chk_str("overrun_lines", q2s(rxq), {"X=0001 Y=0002 Z=0003 T=0004\r\n", "X=0021 Y=0022 Z=0023 T=0024\r\n"});
    chk("overrun_drop", 64'(drop), 64'd1);
    chk("overrun_line_done", 64'(ld_cnt - d0), 64'd2);

    // 5: valid coincident with the last-char accept.
    rxq.delete(); accq.delete();
    send(64'hAB00_CD00_EF00_0100);
    d0 = send_cyc;
    while (cyc < d0 + 29) begin @(posedge clk); #1; end
    data = 64'h00AB_00CD_00EF_0001; valid = 1'b1;
    @(posedge clk); #1; valid = 1'b0;
    wait_idle(500, 1'b0);
    chk_str("coincident_lines", q2s(rxq), {"X=00AB Y=00CD Z=00EF T=0001\r\n", "X=AB00 Y=CD00 Z=EF00 T=0100\r\n"});
    if (accq.size() == 58) chk("coincident_b_start", 64'(accq[29] - d0), 64'd31);
    chk("coincident_drop", 64'(drop), 64'd1);

    // 6: reset mid-line at char 10, then a clean line.
    rxq.delete();
    send(vecs[3].s);
    for (int n = 0; n < 100 && rxq.size() < 10; n++) begin @(posedge clk); #1; end
    #3 rst_n = 1'b0;
    #2;
    chk("async_reset_outputs", {txv, txd, busy, ld, drop}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rxq.delete();
    send(vecs[0].s);
    wait_idle(200, 1'b0);
    chk_str("line_after_reset", q2s(rxq), vecs[0].line);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
